config_latch_prog_ctrl: RTL and testbench

//  Sequences word-line/bit-line programming of a bank of NUM_ROWS x BL_WIDTH

---
 rtl/config_latch_prog_ctrl.sv | 158 +++++++++++++++
 tb/tb_config_latch_prog_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/config_latch_prog_ctrl.sv
// Sequences one config word per row onto the bl bus and pulses that row's wl line.
// Latency: accept->wl rise SETUP_CYCLES, row period 1+SETUP+WL+HOLD; backpressure: in_ready only in LOAD.
module config_latch_prog_ctrl #(
    parameter int NUM_ROWS     = 8,
    parameter int BL_WIDTH     = 16,
    parameter int SETUP_CYCLES = 1,
    parameter int WL_CYCLES    = 2,
    parameter int HOLD_CYCLES  = 1
) (
    input  logic                clk,
    input  logic                resetb,
    input  logic                start,
    input  logic                abort,
    input  logic [BL_WIDTH-1:0] in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [BL_WIDTH-1:0] bl,
    output logic [NUM_ROWS-1:0] wl,
    output logic                busy,
    output logic                done
);

    localparam int RW   = $clog2(NUM_ROWS);
    localparam int MAXS = (SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES;
    localparam int MAXC = (WL_CYCLES > MAXS) ? WL_CYCLES : MAXS;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [RW-1:0]       LAST_ROW   = RW'(NUM_ROWS - 1);
    localparam logic [CW-1:0]       SETUP_LAST = CW'(SETUP_CYCLES - 1);
    localparam logic [CW-1:0]       WL_LAST    = CW'(WL_CYCLES - 1);
    localparam logic [CW-1:0]       HOLD_LAST  = CW'(HOLD_CYCLES - 1);
    localparam logic [NUM_ROWS-1:0] WL_ONE     = NUM_ROWS'(1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SETUP,
        PULSE,
        HOLD,
        DONE
    } state_t;

    state_t              state, state_n;
    logic [RW-1:0]       row, row_n;
    logic [CW-1:0]       cnt, cnt_n;
    logic [BL_WIDTH-1:0] bl_n;
    logic [NUM_ROWS-1:0] wl_n, wl_sel;
    logic                in_ready_n, busy_n, done_n;

    assign wl_sel = WL_ONE << row;

    // wl, in_ready and done default low so each state only raises what it owns.
    always_comb begin
        state_n    = state;
        row_n      = row;
        cnt_n      = cnt;
        bl_n       = bl;
        wl_n       = '0;
        in_ready_n = 1'b0;
        busy_n     = busy;
        done_n     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n    = LOAD;
                    row_n      = '0;
                    busy_n     = 1'b1;
                    in_ready_n = 1'b1;
                end
            end
            LOAD: begin
                if (in_valid && in_ready) begin
                    bl_n    = in_data;
                    cnt_n   = '0;
                    state_n = SETUP;
                end else begin
                    in_ready_n = 1'b1;
                end
            end
            SETUP: begin
                if (cnt == SETUP_LAST) begin
                    cnt_n   = '0;
                    wl_n    = wl_sel;
                    state_n = PULSE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            PULSE: begin
                if (cnt == WL_LAST) begin
                    cnt_n   = '0;
                    state_n = HOLD;
                end else begin
                    cnt_n = cnt + 1'b1;
                    wl_n  = wl_sel;
                end
            end
            HOLD: begin
                if (cnt == HOLD_LAST) begin
                    cnt_n = '0;
                    if (row == LAST_ROW) begin
                        state_n = DONE;
                        done_n  = 1'b1;
                        busy_n  = 1'b0;
                        bl_n    = '0;
                        row_n   = '0;
                    end else begin
                        row_n      = row + 1'b1;
                        in_ready_n = 1'b1;
                        state_n    = LOAD;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        // Abort overrides everything decided above, including a same-cycle accept.
        if (abort && (state != IDLE)) begin
            state_n    = IDLE;
            row_n      = '0;
            cnt_n      = '0;
            bl_n       = '0;
            wl_n       = '0;
            in_ready_n = 1'b0;
            busy_n     = 1'b0;
            done_n     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetb) begin
            state    <= IDLE;
            row      <= '0;
            cnt      <= '0;
            bl       <= '0;
            wl       <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            row      <= row_n;
            cnt      <= cnt_n;
            bl       <= bl_n;
            wl       <= wl_n;
            in_ready <= in_ready_n;
            busy     <= busy_n;
            done     <= done_n;
        end
    end

endmodule

// File: tb/tb_config_latch_prog_ctrl.sv
// Bench for config_latch_prog_ctrl: two timing configurations, driver pushes expected
// row writes into a queue, a negedge monitor checks wl/bl/done timing against them.
module tb_config_latch_prog_ctrl;

    localparam int NR = 8;
    localparam int BW = 16;
    localparam int SC [2] = '{1, 3};
    localparam int WC [2] = '{2, 1};
    localparam int HC [2] = '{1, 2};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          resetb [2];
    logic          start [2];
    logic          abort [2];
    logic          in_valid [2];
    logic [BW-1:0] in_data [2];
    logic          in_ready [2];
    logic [BW-1:0] bl [2];
    logic [NR-1:0] wl [2];
    logic          busy [2];
    logic          done [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        config_latch_prog_ctrl #(
            .NUM_ROWS(NR), .BL_WIDTH(BW),
            .SETUP_CYCLES(SC[g]), .WL_CYCLES(WC[g]), .HOLD_CYCLES(HC[g])
        ) u_dut (
            .clk(clk), .resetb(resetb[g]), .start(start[g]), .abort(abort[g]),
            .in_data(in_data[g]), .in_valid(in_valid[g]), .in_ready(in_ready[g]),
            .bl(bl[g]), .wl(wl[g]), .busy(busy[g]), .done(done[g])
        );
    end

    typedef struct {
        int          row;
        logic [BW-1:0] word;
        bit          last;
        int          acc;
    } item_t;

    typedef struct {
        string       name;
        logic [63:0] a;
        logic [63:0] e;
    } dchk_t;

    item_t exp_q[$];
    dchk_t dq[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endfunction

    // ---------------- monitor / reference model ----------------
    int            rise_c [2], fall_c [2], exp_done [2], n_done [2];
    bit            have_fall [2], pend_zero [2], cur_last [2];
    logic [BW-1:0] cur_word [2];
    logic [NR-1:0] wl_p [2];
    logic          rdy_p [2];

    initial begin
        for (int k = 0; k < 2; k++) begin
            exp_done[k] = -1; n_done[k] = 0; have_fall[k] = 0; pend_zero[k] = 0;
            cur_last[k] = 0; cur_word[k] = '0; wl_p[k] = '0; rdy_p[k] = 1'b0;
            rise_c[k] = 0; fall_c[k] = 0;
        end
    end

    always @(negedge clk) begin
        item_t it;
        dchk_t d;
        while (dq.size() > 0) begin
            d = dq.pop_front();
            chk(d.name, d.a, d.e);
        end
        for (int k = 0; k < 2; k++) begin
            if (pend_zero[k]) begin
                chk("zero_wl", 64'(wl[k]), 0);
                chk("zero_bl", 64'(bl[k]), 0);
                chk("zero_busy", 64'(busy[k]), 0);
                chk("zero_ready", 64'(in_ready[k]), 0);
                chk("zero_done", 64'(done[k]), 0);
                pend_zero[k] = 0;
            end else begin
                if (wl[k] != '0 && wl_p[k] == '0) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_wl", 64'(wl[k]), 0);
                    end else begin
                        it = exp_q.pop_front();
                        chk("wl_row", 64'(wl[k]), 64'(1) << it.row);
                        chk("bl_word", 64'(bl[k]), 64'(it.word));
                        chk("setup_time", 64'(cyc), 64'(it.acc + SC[k]));
                        chk("busy_pulse", 64'(busy[k]), 1);
                        cur_word[k] = it.word;
                        cur_last[k] = it.last;
                        rise_c[k] = cyc;
                    end
                end
                if (wl[k] == '0 && wl_p[k] != '0) begin
                    chk("wl_width", 64'(cyc - rise_c[k]), 64'(WC[k]));
                    chk("bl_hold", 64'(bl[k]), 64'(cur_word[k]));
                    fall_c[k] = cyc;
                    if (cur_last[k]) exp_done[k] = cyc + HC[k];
                    else have_fall[k] = 1;
                end
                if (in_ready[k] && !rdy_p[k] && have_fall[k]) begin
                    chk("ready_time", 64'(cyc), 64'(fall_c[k] + HC[k]));
                    have_fall[k] = 0;
                end
                if (done[k]) begin
                    chk("done_time", 64'(cyc), 64'(exp_done[k]));
                    chk("done_busy", 64'(busy[k]), 0);
                    chk("done_bl", 64'(bl[k]), 0);
                    exp_done[k] = -1;
                    n_done[k]++;
                end else if (exp_done[k] >= 0 && cyc > exp_done[k]) begin
                    chk("done_missing", 0, 1);
                    exp_done[k] = -1;
                end
            end
            if (abort[k] || !resetb[k]) begin
                exp_q.delete();
                pend_zero[k] = 1;
                have_fall[k] = 0;
                exp_done[k] = -1;
            end
            wl_p[k] = wl[k];
            rdy_p[k] = in_ready[k];
        end
    end

    // ---------------- driver ----------------
    task automatic dchk(string n, logic [63:0] a, logic [63:0] e);
        dq.push_back('{n, a, e});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(int k, output int t0);
        start[k] = 1'b1;
        tick();
        start[k] = 1'b0;
        t0 = cyc;
        dchk("start_busy", 64'(busy[k]), 1);
        dchk("start_ready", 64'(in_ready[k]), 1);
    endtask

    task automatic send_word(int k, int row, logic [BW-1:0] w, bit last, int gap, output int acc);
        bit found = 0;
        acc = -1;
        if (gap > 0) begin
            in_valid[k] = 1'b0;
            repeat (gap) tick();
            dchk("ready_held", 64'(in_ready[k]), 1);
            dchk("wl_idle", 64'(wl[k]), 0);
        end
        in_valid[k] = 1'b1;
        in_data[k] = w;
        for (int n = 0; n < 300 && !found; n++) begin
            if (in_ready[k]) begin
                found = 1;
                acc = cyc + 1;
                exp_q.push_back('{row, w, last, acc});
            end
            tick();
        end
        if (!found) dchk("accept_timeout", 0, 1);
    endtask

    task automatic wait_done(int k, output int dc);
        bit found = 0;
        dc = -1;
        for (int n = 0; n < 300 && !found; n++) begin
            if (done[k]) begin
                found = 1;
                dc = cyc;
            end else begin
                tick();
            end
        end
        if (!found) dchk("done_timeout", 0, 1);
    endtask

    task automatic full_seq(int k, int gap_row, bit walk, output int t0, output int dc);
        int acc;
        logic [BW-1:0] w;
        do_start(k, t0);
        for (int i = 0; i < NR; i++) begin
            w = walk ? (BW'(1) << i) : BW'($urandom);
            send_word(k, i, w, i == NR - 1, (i == gap_row) ? 5 : 0, acc);
        end
        in_valid[k] = 1'b0;
        wait_done(k, dc);
        tick();
        dchk("done_one_cycle", 64'(done[k]), 0);
        dchk("idle_busy", 64'(busy[k]), 0);
    endtask

    initial begin
        int t0, dc, acc, nd;
        logic [BW-1:0] w;
        #4000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int t0, dc, acc, nd;
        logic [BW-1:0] w;
        for (int k = 0; k < 2; k++) begin
            resetb[k] = 1'b0; start[k] = 1'b0; abort[k] = 1'b0;
            in_valid[k] = 1'b0; in_data[k] = '0;
        end
        repeat (3) tick();
        for (int k = 0; k < 2; k++) resetb[k] = 1'b1;
        tick();

        // 1: walking-one words, in_valid held, exact done cycle
        full_seq(0, -1, 1, t0, dc);
        dchk("t1_done_cycle", 64'(dc - t0), 64'(NR * (1 + SC[0] + WC[0] + HC[0])));

        // 2: in_valid gap before row 3
        full_seq(0, 3, 0, t0, dc);

        // 3: abort in PULSE of row 2, then abort vs accept in LOAD, then reprogram
        nd = n_done[0];
        do_start(0, t0);
        for (int i = 0; i < 3; i++) send_word(0, i, BW'($urandom), 0, 0, acc);
        repeat (SC[0]) tick();
        dchk("t3_wl_row2", 64'(wl[0]), 64'(1) << 2);
        abort[0] = 1'b1;
        in_valid[0] = 1'b0;
        tick();
        abort[0] = 1'b0;
        dchk("t3_abort_wl", 64'(wl[0]), 0);
        dchk("t3_abort_busy", 64'(busy[0]), 0);
        repeat (20) tick();
        dchk("t3_no_done", 64'(n_done[0] - nd), 0);
        do_start(0, t0);
        in_valid[0] = 1'b1;
        in_data[0] = 16'hA5C3;
        abort[0] = 1'b1;
        tick();
        abort[0] = 1'b0;
        in_valid[0] = 1'b0;
        dchk("t3_race_bl", 64'(bl[0]), 0);
        dchk("t3_race_ready", 64'(in_ready[0]), 0);
        repeat (10) tick();
        full_seq(0, -1, 0, t0, dc);

        // 4: reset pulse during HOLD of row 5, then restart from row 0
        do_start(0, t0);
        for (int i = 0; i < 6; i++) send_word(0, i, BW'($urandom), 0, 0, acc);
        repeat (SC[0] + WC[0]) tick();
        resetb[0] = 1'b0;
        in_valid[0] = 1'b0;
        tick();
        resetb[0] = 1'b1;
        dchk("t4_reset_bl", 64'(bl[0]), 0);
        dchk("t4_reset_busy", 64'(busy[0]), 0);
        tick();
        full_seq(0, -1, 0, t0, dc);

        // 5: start while busy and during the done cycle is ignored
        nd = n_done[0];
        do_start(0, t0);
        for (int i = 0; i < NR; i++) begin
            send_word(0, i, BW'($urandom), i == NR - 1, 0, acc);
            if (i == 3) begin
                start[0] = 1'b1;
                tick();
                start[0] = 1'b0;
            end
        end
        in_valid[0] = 1'b0;
        wait_done(0, dc);
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        dchk("t5_idle_busy", 64'(busy[0]), 0);
        dchk("t5_idle_ready", 64'(in_ready[0]), 0);
        tick();
        tick();
        dchk("t5_still_idle", 64'(busy[0]), 0);
        dchk("t5_one_done", 64'(n_done[0] - nd), 1);

        // 6: SETUP=3, WL=1, HOLD=2 instance
        full_seq(1, -1, 0, t0, dc);
        dchk("t6_done_cycle", 64'(dc - t0), 64'(NR * (1 + SC[1] + WC[1] + HC[1])));

        tick();
        dchk("queue_empty", 64'(exp_q.size()), 0);
        tick();
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
